// File: rtl/power_pkg.sv
`default_nettype none
// ============================================================================
// power_pkg : power-state encoding, power-down step codes and state helper
// Revision  : 1.0
// ============================================================================
package power_pkg;

    typedef enum logic [2:0] {
        PS_SHUTDOWN  = 3'd0,
        PS_DEEPSLEEP = 3'd1,
        PS_SLEEP     = 3'd2,
        PS_ACTIVE    = 3'd3,
        PS_PWRUP     = 3'd4,
        PS_PWRDN     = 3'd5
    } power_state_e;

    // One code per cycle of the fixed power-down sequence
    localparam logic [1:0] PD_SAVE = 2'd0;
    localparam logic [1:0] PD_ISO  = 2'd1;
    localparam logic [1:0] PD_OFF  = 2'd2;

    function automatic logic ps_is_run(input power_state_e s);
        return (s == PS_ACTIVE) || (s == PS_SLEEP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/power_idle_timer.sv
`default_nettype none
// ============================================================================
// power_idle_timer : saturating idle counter with clear, enable and match flag
// Revision         : 1.0
// ============================================================================
module power_idle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] timeout,
    output logic             match
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the idle cycle that completes the programmed count; zero disables
    assign match = en && (timeout != '0) && (count_q == (timeout - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/power_seq_ctrl.sv
`default_nettype none
// ============================================================================
// power_seq_ctrl : core-domain power mode controller with up/down sequencing
// Revision       : 1.0
// ============================================================================
module power_seq_ctrl
    import power_pkg::*;
#(
    parameter int NUM_WAKE    = 4,
    parameter int CNT_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_WAKE-1:0] wake_src,
    input  logic [NUM_WAKE-1:0] wake_mask,
    input  logic                radio_request,
    input  logic                cpu_idle,
    input  logic                radio_idle,
    input  logic                shutdown_cmd,
    input  logic [CNT_W-1:0]    sleep_timeout,
    input  logic [CNT_W-1:0]    deep_timeout,
    input  logic                pwr_ack,
    output logic [2:0]          power_state,
    output logic                pwr_en,
    output logic                iso_en,
    output logic                clk_en,
    output logic                ret_save,
    output logic                ret_restore,
    output logic                wake_pending,
    output logic                pwr_fault
);

    localparam int SET_W = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [ACK_W-1:0] ACK_LAST    = ACK_W'(ACK_TIMEOUT - 1);

    power_state_e     state_q,  state_d;
    power_state_e     target_q, target_d;
    logic [1:0]       pd_step_q, pd_step_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             pwr_en_q, pwr_en_d;
    logic             iso_en_q, iso_en_d;
    logic             clk_en_q, clk_en_d;
    logic             ret_save_q, ret_save_d;
    logic             ret_restore_q, ret_restore_d;
    logic             wake_pending_q, wake_pending_d;
    logic             pwr_fault_q, pwr_fault_d;

    logic             wake_w;
    logic             idle_w;
    logic             timer_en;
    logic             timer_clr;
    logic             timer_match;
    logic [CNT_W-1:0] timer_limit;

    assign wake_w = (|(wake_src & ~wake_mask)) | radio_request;
    assign idle_w = cpu_idle & radio_idle & ~radio_request;

    assign timer_en    = idle_w && ps_is_run(state_q);
    assign timer_clr   = !timer_en || (state_d != state_q);
    assign timer_limit = (state_q == PS_SLEEP) ? deep_timeout : sleep_timeout;

    power_idle_timer #(
        .CNT_W (CNT_W)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .timeout (timer_limit),
        .match   (timer_match)
    );

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        pd_step_d      = PD_SAVE;
        settle_d       = '0;
        ack_cnt_d      = '0;
        ret_restore_d  = 1'b0;
        pwr_fault_d    = pwr_fault_q;
        wake_pending_d = wake_pending_q | (wake_w && (state_q != PS_ACTIVE));

        case (state_q)
            PS_SHUTDOWN: begin
                if (wake_w) state_d = PS_DEEPSLEEP;
            end
            PS_DEEPSLEEP: begin
                if (shutdown_cmd) begin
                    state_d = PS_SHUTDOWN;
                end else if (wake_w || wake_pending_q) begin
                    state_d = PS_PWRUP;
                end
            end
            PS_PWRUP: begin
                // Settle needs consecutive ack cycles; timeout needs consecutive non-ack cycles
                if (pwr_ack) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d       = PS_ACTIVE;
                        ret_restore_d = 1'b1;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end else if (ack_cnt_q == ACK_LAST) begin
                    pwr_fault_d = 1'b1;
                    state_d     = PS_DEEPSLEEP;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            PS_ACTIVE: begin
                if (shutdown_cmd) begin
                    state_d  = PS_PWRDN;
                    target_d = PS_SHUTDOWN;
                end else if (timer_match) begin
                    state_d = PS_SLEEP;
                end
            end
            PS_SLEEP: begin
                if (shutdown_cmd) begin
                    state_d  = PS_PWRDN;
                    target_d = PS_SHUTDOWN;
                end else if (wake_w || !cpu_idle) begin
                    state_d = PS_ACTIVE;
                end else if (timer_match) begin
                    state_d  = PS_PWRDN;
                    target_d = PS_DEEPSLEEP;
                end
            end
            PS_PWRDN: begin
                if (pd_step_q == PD_OFF) begin
                    state_d = target_q;
                end else begin
                    pd_step_d = pd_step_q + 2'd1;
                end
            end
            default: begin
                state_d        = PS_SHUTDOWN;
                target_d       = PS_SHUTDOWN;
                wake_pending_d = 1'b0;
            end
        endcase

        if (state_d == PS_ACTIVE) wake_pending_d = 1'b0;

        // Rail, isolation and clock controls follow the state being entered
        pwr_en_d = 1'b0;
        iso_en_d = 1'b1;
        case (state_d)
            PS_PWRUP: begin
                pwr_en_d = 1'b1;
            end
            PS_ACTIVE, PS_SLEEP: begin
                pwr_en_d = 1'b1;
                iso_en_d = 1'b0;
            end
            PS_PWRDN: begin
                pwr_en_d = (pd_step_d != PD_OFF);
                iso_en_d = (pd_step_d == PD_ISO) || (pd_step_d == PD_OFF);
            end
            default: begin
                pwr_en_d = 1'b0;
                iso_en_d = 1'b1;
            end
        endcase
        clk_en_d   = (state_d == PS_ACTIVE);
        ret_save_d = (state_d == PS_PWRDN) && (pd_step_d == PD_SAVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PS_SHUTDOWN;
            target_q       <= PS_SHUTDOWN;
            pd_step_q      <= PD_SAVE;
            settle_q       <= '0;
            ack_cnt_q      <= '0;
            pwr_en_q       <= 1'b0;
            iso_en_q       <= 1'b1;
            clk_en_q       <= 1'b0;
            ret_save_q     <= 1'b0;
            ret_restore_q  <= 1'b0;
            wake_pending_q <= 1'b0;
            pwr_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            pd_step_q      <= pd_step_d;
            settle_q       <= settle_d;
            ack_cnt_q      <= ack_cnt_d;
            pwr_en_q       <= pwr_en_d;
            iso_en_q       <= iso_en_d;
            clk_en_q       <= clk_en_d;
            ret_save_q     <= ret_save_d;
            ret_restore_q  <= ret_restore_d;
            wake_pending_q <= wake_pending_d;
            pwr_fault_q    <= pwr_fault_d;
        end
    end

    assign power_state  = state_q;
    assign pwr_en       = pwr_en_q;
    assign iso_en       = iso_en_q;
    assign clk_en       = clk_en_q;
    assign ret_save     = ret_save_q;
    assign ret_restore  = ret_restore_q;
    assign wake_pending = wake_pending_q;
    assign pwr_fault    = pwr_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_power_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_power_seq_ctrl : directed + random checks of power_seq_ctrl vs a mode model
// Revision          : 1.0
// ============================================================================
module tb_power_seq_ctrl;

    localparam int NW     = 4;
    localparam int CW     = 16;
    localparam int SETTLE = 8;
    localparam int ACKTO  = 64;

    localparam int M_SHUTDOWN  = 0;
    localparam int M_DEEPSLEEP = 1;
    localparam int M_SLEEP     = 2;
    localparam int M_ACTIVE    = 3;
    localparam int M_PWRUP     = 4;
    localparam int M_PWRDN     = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NW-1:0] wake_src;
    logic [NW-1:0] wake_mask;
    logic          radio_request;
    logic          cpu_idle;
    logic          radio_idle;
    logic          shutdown_cmd;
    logic [CW-1:0] sleep_timeout;
    logic [CW-1:0] deep_timeout;
    logic          pwr_ack;
    logic [2:0]    power_state;
    logic          pwr_en;
    logic          iso_en;
    logic          clk_en;
    logic          ret_save;
    logic          ret_restore;
    logic          wake_pending;
    logic          pwr_fault;

    power_seq_ctrl #(
        .NUM_WAKE    (NW),
        .CNT_W       (CW),
        .SETTLE_CYC  (SETTLE),
        .ACK_TIMEOUT (ACKTO)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .wake_src      (wake_src),
        .wake_mask     (wake_mask),
        .radio_request (radio_request),
        .cpu_idle      (cpu_idle),
        .radio_idle    (radio_idle),
        .shutdown_cmd  (shutdown_cmd),
        .sleep_timeout (sleep_timeout),
        .deep_timeout  (deep_timeout),
        .pwr_ack       (pwr_ack),
        .power_state   (power_state),
        .pwr_en        (pwr_en),
        .iso_en        (iso_en),
        .clk_en        (clk_en),
        .ret_save      (ret_save),
        .ret_restore   (ret_restore),
        .wake_pending  (wake_pending),
        .pwr_fault     (pwr_fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: current mode plus run-length counters of the relevant conditions
    int m_mode;
    int pd_step;
    int pd_tgt;
    int idle_run;
    int ack_low;
    int ack_high;
    bit pend;
    bit fault;
    bit restore;

    task automatic model_reset();
        m_mode   = M_SHUTDOWN;
        pd_step  = 0;
        pd_tgt   = M_SHUTDOWN;
        idle_run = 0;
        ack_low  = 0;
        ack_high = 0;
        pend     = 1'b0;
        fault    = 1'b0;
        restore  = 1'b0;
    endtask

    task automatic model_step();
        bit w;
        bit idl;
        int nxt;
        w   = ((wake_src & ~wake_mask) != '0) || radio_request;
        idl = cpu_idle && radio_idle && !radio_request;
        nxt = m_mode;
        restore = 1'b0;
        case (m_mode)
            M_SHUTDOWN: if (w) nxt = M_DEEPSLEEP;
            M_DEEPSLEEP: begin
                if (shutdown_cmd) nxt = M_SHUTDOWN;
                else if (w || pend) nxt = M_PWRUP;
            end
            M_PWRUP: begin
                if (pwr_ack) begin
                    ack_low  = 0;
                    ack_high = ack_high + 1;
                    if (ack_high == SETTLE) begin
                        nxt     = M_ACTIVE;
                        restore = 1'b1;
                    end
                end else begin
                    ack_high = 0;
                    ack_low  = ack_low + 1;
                    if (ack_low == ACKTO) begin
                        fault = 1'b1;
                        nxt   = M_DEEPSLEEP;
                    end
                end
            end
            M_ACTIVE: begin
                if (shutdown_cmd) begin
                    nxt    = M_PWRDN;
                    pd_tgt = M_SHUTDOWN;
                end else if (idl) begin
                    idle_run = idle_run + 1;
                    if (sleep_timeout != 0 && idle_run == int'(sleep_timeout)) nxt = M_SLEEP;
                end else begin
                    idle_run = 0;
                end
            end
            M_SLEEP: begin
                if (shutdown_cmd) begin
                    nxt    = M_PWRDN;
                    pd_tgt = M_SHUTDOWN;
                end else if (w || !cpu_idle) begin
                    nxt = M_ACTIVE;
                end else if (idl) begin
                    idle_run = idle_run + 1;
                    if (deep_timeout != 0 && idle_run == int'(deep_timeout)) begin
                        nxt    = M_PWRDN;
                        pd_tgt = M_DEEPSLEEP;
                    end
                end else begin
                    idle_run = 0;
                end
            end
            default: begin
                pd_step = pd_step + 1;
                if (pd_step == 3) nxt = pd_tgt;
            end
        endcase
        if (nxt != m_mode) begin
            idle_run = 0;
            ack_low  = 0;
            ack_high = 0;
            pd_step  = 0;
        end
        pend   = (nxt == M_ACTIVE) ? 1'b0 : (pend || (w && m_mode != M_ACTIVE));
        m_mode = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit e_pwr;
        bit e_iso;
        e_pwr = (m_mode == M_PWRUP) || (m_mode == M_ACTIVE) || (m_mode == M_SLEEP)
                || (m_mode == M_PWRDN && pd_step < 2);
        e_iso = !((m_mode == M_ACTIVE) || (m_mode == M_SLEEP) || (m_mode == M_PWRDN && pd_step == 0));
        chk("power_state",  32'(power_state),  32'(m_mode));
        chk("pwr_en",       32'(pwr_en),       32'(e_pwr));
        chk("iso_en",       32'(iso_en),       32'(e_iso));
        chk("clk_en",       32'(clk_en),       32'(m_mode == M_ACTIVE));
        chk("ret_save",     32'(ret_save),     32'(m_mode == M_PWRDN && pd_step == 0));
        chk("ret_restore",  32'(ret_restore),  32'(restore));
        chk("wake_pending", 32'(wake_pending), 32'(pend));
        chk("pwr_fault",    32'(pwr_fault),    32'(fault));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    bit ack_good;

    initial begin
        reset = 1'b1;
        wake_src = '0;
        wake_mask = '0;
        radio_request = 1'b0;
        cpu_idle = 1'b0;
        radio_idle = 1'b0;
        shutdown_cmd = 1'b0;
        sleep_timeout = '0;
        deep_timeout = '0;
        pwr_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Masked wake in SHUTDOWN has no effect
        wake_src = 4'b0001;
        wake_mask = 4'b0001;
        repeat (3) tick();
        chk("masked_wake_state", 32'(power_state), M_SHUTDOWN);

        // Unmasked wake: DEEPSLEEP, PWRUP, ack after 3 cycles, settle, ACTIVE
        wake_mask = 4'b0000;
        tick();
        chk("wake_to_deepsleep", 32'(power_state), M_DEEPSLEEP);
        wake_src = '0;
        tick();
        chk("deepsleep_to_pwrup", 32'(power_state), M_PWRUP);
        repeat (2) tick();
        pwr_ack = 1'b1;
        repeat (SETTLE - 1) tick();
        chk("still_settling", 32'(power_state), M_PWRUP);
        tick();
        chk("settled_active", 32'(power_state), M_ACTIVE);
        chk("restore_pulse", 32'(ret_restore), 1);
        tick();
        chk("restore_single", 32'(ret_restore), 0);

        // Idle break at 9 restarts the count; then exactly 10 idle cycles to SLEEP
        sleep_timeout = 16'd10;
        deep_timeout = 16'd5;
        cpu_idle = 1'b1;
        radio_idle = 1'b1;
        repeat (9) tick();
        cpu_idle = 1'b0;
        tick();
        cpu_idle = 1'b1;
        repeat (9) tick();
        chk("idle_nine_active", 32'(power_state), M_ACTIVE);
        tick();
        chk("idle_ten_sleep", 32'(power_state), M_SLEEP);

        // SLEEP -> PWRDN(DEEPSLEEP) with a wake arriving mid-sequence
        pwr_ack = 1'b0;
        repeat (4) tick();
        chk("deep_four_sleep", 32'(power_state), M_SLEEP);
        tick();
        chk("pwrdn_save", 32'(ret_save), 1);
        wake_src = 4'b0010;
        tick();
        chk("pwrdn_iso", 32'(iso_en), 1);
        wake_src = '0;
        tick();
        chk("pwrdn_off", 32'(pwr_en), 0);
        tick();
        chk("pwrdn_deepsleep", 32'(power_state), M_DEEPSLEEP);
        tick();
        chk("pending_pwrup", 32'(power_state), M_PWRUP);

        // Ack stuck low: fault after ACKTO cycles
        repeat (ACKTO - 1) tick();
        chk("no_fault_yet", 32'(pwr_fault), 0);
        tick();
        chk("fault_set", 32'(pwr_fault), 1);
        chk("fault_deepsleep", 32'(power_state), M_DEEPSLEEP);
        chk("fault_pwr_off", 32'(pwr_en), 0);
        pwr_ack = 1'b1;
        repeat (SETTLE + 2) tick();
        chk("retry_active", 32'(power_state), M_ACTIVE);

        // Shutdown and radio request together in SLEEP
        sleep_timeout = 16'd3;
        deep_timeout = 16'd0;
        repeat (3) tick();
        chk("short_sleep", 32'(power_state), M_SLEEP);
        shutdown_cmd = 1'b1;
        radio_request = 1'b1;
        tick();
        chk("shutdown_wins", 32'(power_state), M_PWRDN);
        shutdown_cmd = 1'b0;
        radio_request = 1'b0;
        repeat (3) tick();
        chk("to_shutdown", 32'(power_state), M_SHUTDOWN);

        // Reset during PWRUP settle returns outputs at once
        wake_src = 4'b0100;
        repeat (2) tick();
        wake_src = '0;
        repeat (3) tick();
        chk("settling_before_reset", 32'(power_state), M_PWRUP);
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random phase against the model
        ack_good = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 150 == 0) begin
                sleep_timeout = 16'($urandom_range(0, 12));
                deep_timeout = 16'($urandom_range(0, 12));
            end
            if (cyc % 97 == 0) ack_good = ($urandom_range(0, 2) != 0);
            wake_src = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            wake_mask = 4'($urandom);
            radio_request = ($urandom_range(0, 15) == 0);
            cpu_idle = ($urandom_range(0, 3) != 0);
            radio_idle = ($urandom_range(0, 3) != 0);
            shutdown_cmd = ($urandom_range(0, 39) == 0);
            pwr_ack = ack_good && ($urandom_range(0, 15) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
